debounced_pio: RTL
==================

DEBOUNCED_PIO -- requirements
Module: debounced_pio

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of input channels, legal range 1..32.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new level; minimum 1.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: when 1, raw inputs are inverted before all processing.
REQ-004 SHALL provide parameter EDGE_MODE, default 1: 0 = rising, 1 = falling, 2 = any edge of the logical (post-inversion) debounced value.
REQ-005 SHALL use one clock and a synchronous, active-high reset; clk and reset are the only clock/reset ports.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 raw_in  input  WIDTH  asynchronous pushbutton/switch pins.
REQ-009 address  input  2  Avalon-MM word address.
REQ-010 chipselect  input  1  slave select.
REQ-011 read  input  1  read strobe.
REQ-012 write  input  1  write strobe.
REQ-013 writedata  input  32  write data.
REQ-014 readdata  output  32  registered read data.
REQ-015 irq  output  1  level interrupt request.

Function
REQ-016 SHALL pass each raw_in bit (after optional inversion) through a 2-flop synchroniser before debouncing.
REQ-017 SHALL keep per bit a stable value and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-018 Counter SHALL clear whenever synchronised bit equals stable value, else increment by 1.
REQ-019 When counter would reach DEBOUNCE_CYCLES, stable bit SHALL take the synchronised value that cycle and counter SHALL clear; no saturation or wrap beyond DEBOUNCE_CYCLES.
REQ-020 Latency raw_in change -> stable change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a glitch-free input.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL not change stable value.
REQ-022 Edge detector SHALL compare stable with its 1-cycle-delayed copy; a qualifying edge (per EDGE_MODE) SHALL set the edge-capture bit the cycle after the stable change.
REQ-023 Register map: addr 0 data (RO, stable[WIDTH-1:0]); addr 1 reserved (reads 0, writes ignored); addr 2 irq mask (RW); addr 3 edge capture (read; write-1-to-clear per bit).
REQ-024 Unused upper readdata bits SHALL read 0; writes to bits >= WIDTH SHALL be ignored.
REQ-025 readdata SHALL be registered: valid 1 cycle after chipselect&read; holds value otherwise; no wait states.
REQ-026 On simultaneous clear-write and new edge on the same bit, set SHALL win (bit remains 1).
REQ-027 irq SHALL equal registered OR of (edge_capture & mask), asserted 1 cycle after the capture bit or mask bit sets, deasserted 1 cycle after clear.
REQ-028 Simultaneous read and write to different addresses in one cycle SHALL both take effect; read of addr 3 in the clearing cycle SHALL return pre-clear value.

Reset
REQ-029 On reset: synchronisers, stable, delayed copy, counters, mask, edge capture, readdata, irq SHALL all be 0 (logical inactive).
REQ-030 Reset asserted mid-debounce SHALL discard partial counts; after release, a held input requires full 2 + DEBOUNCE_CYCLES again.
REQ-031 Reset SHALL take priority over every write and edge in the same cycle.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1, EDGE_MODE=1)
REQ-032 raw_in 4'hF -> 4'hE held -> data reads 4'h1 after exactly 6 cycles; then raw_in back to 4'hF -> edge capture reads 4'h1, irq stays 0 with mask 0.
REQ-033 raw_in bit0 low for 3 cycles then high -> data stays 4'h0, capture 4'h0 (glitch rejected).
REQ-034 Mask=4'h1, press/release bit0 -> irq=1 one cycle after capture bit0 sets; write 32'h1 to addr 3 -> capture 0, irq 0 next cycle.
REQ-035 Release edge coincident with write 32'h1 to addr 3 -> capture bit0 stays 1, irq stays 1.
REQ-036 Reset pulsed 2 cycles into a 4-cycle debounce -> no stable change until 6 cycles after reset release; mask and capture read 0.
REQ-037 Write 32'hFFFF_FFFF to addr 2 -> reads 32'h0000_000F; read addr 1 -> 32'h0.

Source files
------------

// File: rtl/debounced_pio.sv
// Debounced parallel input port with Avalon-MM slave, edge capture and masked level irq.
// Latency: raw_in -> data register 2 + DEBOUNCE_CYCLES cycles; readdata 1 cycle after read.
// Backpressure: none; the slave never inserts wait states and every access completes in one cycle.
module debounced_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int EDGE_MODE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0] raw_log;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] clr_bits;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [31:0]      rd_mux;
    logic             wr_sel;
    logic             rd_sel;
    logic             unused_wdata;

    assign raw_log      = ACTIVE_LOW ? ~raw_in : raw_in;
    assign wr_sel       = chipselect & write;
    assign rd_sel       = chipselect & read;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_log;
            sync2 <= sync1;
        end
    end

    // Counter restarts on any agreement, so only an unbroken run of DEBOUNCE_CYCLES flips a bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            0:       edge_hit = stable & ~stable_d;
            1:       edge_hit = ~stable & stable_d;
            default: edge_hit = stable ^ stable_d;
        endcase
    end

    assign clr_bits = (wr_sel && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            edge_cap <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~clr_bits) | edge_hit;
            if (wr_sel && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_cap & mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
            ADDR_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_sel) begin
            readdata <= rd_mux;
        end
    end

endmodule
